// File: rtl/ysyx_22050133_axi_sram.sv
// AXI slave SRAM behind the IF/LSU arbiter: independent read/write FSMs,
// 1- or 2-beat INCR bursts, programmable read latency, byte strobes, SLVERR.
module ysyx_22050133_axi_sram #(
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
   parameter logic [AXI_ADDR_WIDTH-1:0] MEM_BASE = 32'h8000_0000,
   parameter int MEM_DEPTH = 4096,
   parameter int RD_LAT = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic                      axi_aw_ready_o,
   input  logic                      axi_aw_valid_i,
   input  logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr_i,
   input  logic                      axi_aw_len_i,
   output logic                      axi_w_ready_o,
   input  logic                      axi_w_valid_i,
   input  logic [AXI_DATA_WIDTH-1:0] axi_w_data_i,
   input  logic [AXI_STRB_WIDTH-1:0] axi_w_strb_i,
   input  logic                      axi_b_ready_i,
   output logic                      axi_b_valid_o,
   output logic [1:0]                axi_b_resp_o,
   output logic                      axi_ar_ready_o,
   input  logic                      axi_ar_valid_i,
   input  logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr_i,
   input  logic                      axi_ar_len_i,
   input  logic                      axi_r_ready_i,
   output logic                      axi_r_valid_o,
   output logic [1:0]                axi_r_resp_o,
   output logic [AXI_DATA_WIDTH-1:0] axi_r_data_o
);

   localparam int IW = $clog2(MEM_DEPTH);
   localparam logic [AXI_ADDR_WIDTH:0] MEM_END =
      {1'b0, MEM_BASE} + (AXI_ADDR_WIDTH+1)'(8 * MEM_DEPTH);

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

   logic [AXI_DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

   rd_state_t                 r_rstate;
   rd_state_t                 w_rnext;
   logic [IW-1:0]             r_ridx;
   logic                      r_rlen;
   logic                      r_rbeat;
   logic                      r_rerr;
   logic [3:0]                r_rcnt;
   logic [AXI_DATA_WIDTH-1:0] r_rdata;

   wr_state_t                 r_wstate;
   wr_state_t                 w_wnext;
   logic [IW-1:0]             r_widx;
   logic                      r_wlen;
   logic                      r_wbeat;
   logic                      r_werr;

   logic [AXI_ADDR_WIDTH-1:0] w_ar_off;
   logic [AXI_ADDR_WIDTH-1:0] w_aw_off;
   logic [IW-1:0]             w_ar_idx;
   logic [IW-1:0]             w_aw_idx;
   logic                      w_ar_err;
   logic                      w_aw_err;
   logic [IW-1:0]             w_rd_idx;
   logic [IW-1:0]             w_wr_idx;
   logic                      w_wr_en;
   logic                      w_unused;

   // Offsets wrap modulo MEM_DEPTH; only the base address is range-checked.
   assign w_ar_off = axi_ar_addr_i - MEM_BASE;
   assign w_aw_off = axi_aw_addr_i - MEM_BASE;
   assign w_ar_idx = w_ar_off[IW+2:3];
   assign w_aw_idx = w_aw_off[IW+2:3];
   assign w_ar_err = (axi_ar_addr_i < MEM_BASE) ||
                     ({1'b0, axi_ar_addr_i} >= MEM_END);
   assign w_aw_err = (axi_aw_addr_i < MEM_BASE) ||
                     ({1'b0, axi_aw_addr_i} >= MEM_END);
   assign w_rd_idx = r_ridx + {{(IW-1){1'b0}}, r_rbeat};
   assign w_wr_idx = r_widx + {{(IW-1){1'b0}}, r_wbeat};
   assign w_unused = ^{w_ar_off, w_aw_off};

   assign axi_ar_ready_o = rst & (r_rstate == R_IDLE);
   assign axi_r_valid_o  = (r_rstate == R_DATA);
   assign axi_r_resp_o   = axi_r_valid_o ? {r_rerr, 1'b0} : 2'b00;
   assign axi_r_data_o   = r_rdata;

   assign axi_aw_ready_o = rst & (r_wstate == W_IDLE);
   assign axi_w_ready_o  = (r_wstate == W_DATA);
   assign axi_b_valid_o  = (r_wstate == W_RESP);
   assign axi_b_resp_o   = axi_b_valid_o ? {r_werr, 1'b0} : 2'b00;

   assign w_wr_en = axi_w_ready_o & axi_w_valid_i & ~r_werr;

   always_comb begin
      w_rnext = r_rstate;
      unique case (r_rstate)
         R_IDLE:
            if (axi_ar_valid_i)
               w_rnext = (RD_LAT == 0) ? R_DATA : R_WAIT;
         R_WAIT:
            if (r_rcnt == 4'd1) w_rnext = R_DATA;
         R_DATA:
            if (axi_r_ready_i && (r_rbeat == r_rlen)) w_rnext = R_IDLE;
         default: w_rnext = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rstate <= R_IDLE;
         r_ridx   <= '0;
         r_rlen   <= 1'b0;
         r_rbeat  <= 1'b0;
         r_rerr   <= 1'b0;
         r_rcnt   <= 4'd0;
         r_rdata  <= '0;
      end else begin
         r_rstate <= w_rnext;
         unique case (r_rstate)
            R_IDLE:
               if (axi_ar_valid_i) begin
                  r_ridx  <= w_ar_idx;
                  r_rlen  <= axi_ar_len_i;
                  r_rbeat <= 1'b0;
                  r_rerr  <= w_ar_err;
                  r_rcnt  <= 4'(RD_LAT);
                  if (RD_LAT == 0)
                     r_rdata <= w_ar_err ? '0 : r_mem[w_ar_idx];
               end
            R_WAIT: begin
               r_rcnt <= r_rcnt - 4'd1;
               if (r_rcnt == 4'd1)
                  r_rdata <= r_rerr ? '0 : r_mem[w_rd_idx];
            end
            R_DATA:
               if (axi_r_ready_i && (r_rbeat != r_rlen)) begin
                  r_rbeat <= 1'b1;
                  r_rdata <= r_rerr ? '0 : r_mem[w_rd_idx + IW'(1)];
               end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_wnext = r_wstate;
      unique case (r_wstate)
         W_IDLE:
            if (axi_aw_valid_i) w_wnext = W_DATA;
         W_DATA:
            if (axi_w_valid_i && (r_wbeat == r_wlen)) w_wnext = W_RESP;
         W_RESP:
            if (axi_b_ready_i) w_wnext = W_IDLE;
         default: w_wnext = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wstate <= W_IDLE;
         r_widx   <= '0;
         r_wlen   <= 1'b0;
         r_wbeat  <= 1'b0;
         r_werr   <= 1'b0;
      end else begin
         r_wstate <= w_wnext;
         if (axi_aw_ready_o && axi_aw_valid_i) begin
            r_widx  <= w_aw_idx;
            r_wlen  <= axi_aw_len_i;
            r_wbeat <= 1'b0;
            r_werr  <= w_aw_err;
         end else if (axi_w_ready_o && axi_w_valid_i) begin
            r_wbeat <= 1'b1;
         end
      end
   end

   // Storage is never reset; contents survive rst.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int k = 0; k < AXI_STRB_WIDTH; k++) begin
            if (axi_w_strb_i[k])
               r_mem[w_wr_idx][8*k +: 8] <= axi_w_data_i[8*k +: 8];
         end
      end
   end

endmodule
